pulse_counter_watchdog: RTL and testbench
=========================================

// Module: pulse_counter_watchdog
// PURPOSE
//   Parametrised successor to the fixed 4-bit pulse counter. Counts rising edges of the
//   pulse input up to a programmable target and raises done when it gets there.
//   Also runs an inter-pulse watchdog: timeout is raised if no edge arrives within
//   TIMEOUT cycles. Sits between a pulse/event source and control logic that needs
//   "N events seen" or "event stream stalled" status.
// PARAMETERS
//   CNT_W        4    width of count output/register
//   TARGET       10   edges required for done; legal range 1..2^CNT_W-1 (elab-time check)
//   TO_W         8    width of watchdog timer
//   TIMEOUT      100  max idle cycles between counted edges; legal range 1..2^TO_W-1
//   AUTO_RELOAD  0    0 = one-shot, hold in DONE; 1 = restart counting after done
// PORTS
//   clk      in   1      rising-edge clock
//   rst      in   1      asynchronous, active-low reset
//   en       in   1      start/run enable; low pauses count and timer
//   clear    in   1      synchronous clear to IDLE
//   pulse    in   1      event input, level; rising edges are counted
//   count    out  CNT_W  edges counted in current run
//   done     out  1      target reached
//   timeout  out  1      watchdog expired (sticky until clear)
//   busy     out  1      high in COUNT state
// BEHAVIOUR
// - Reset (rst=0): state=IDLE; count=0; timer=0; done=0; timeout=0; busy=0.
//   pulse_q resets to 1, so a pulse held high through reset is not counted.
// - Edge detect: pulse_q <= pulse every clk. rise = pulse & ~pulse_q.
//   The increment is visible on count 1 clk after the sampled rise.
// - Priority: rst > clear > FSM. clear forces IDLE, count=0, timer=0, done=0, timeout=0.
// - FSM states: IDLE, COUNT, DONE, TOUT.
//   - IDLE: count=0, timer=0. en=1 -> COUNT on next clk. Edges in IDLE are ignored.
//   - COUNT (busy=1), when en=0: count and timer hold; no timeout accrues.
//   - COUNT, en=1 and rise: count+1, timer<=0.
//     If count+1==TARGET -> DONE, done=1 from that clk.
//   - COUNT, en=1 and no rise: timer+1.
//     If timer==TIMEOUT-1 -> TOUT, timeout=1, count frozen.
//     Timeout therefore fires after TIMEOUT consecutive edge-free enabled cycles.
//   - Simultaneous rise and timer expiry: the rise wins; count increments, no timeout.
//   - DONE, AUTO_RELOAD=0: hold done=1 and count=TARGET. Ignore edges. Exit only via clear/rst.
//   - DONE, AUTO_RELOAD=1: done is a 1-clk pulse. Next clk returns to COUNT with count=0, timer=0.
//     A rise in that DONE cycle is not counted.
//   - TOUT: hold; timeout=1, count frozen. Exit only via clear/rst.
// - Arithmetic: count never wraps (stops at TARGET). timer never exceeds TIMEOUT-1.
// - Mid-operation rst: immediate async return to reset values.
// CONFIGURATION
//   PULSE_SYNC_EN defined:
//     - Pulse passes through a 2-flop synchroniser (reset value 1) before edge detect.
//     - Every edge-to-count latency grows by 2 clk.
//     - Use this for asynchronous pulse sources.
//   PULSE_SYNC_EN undefined:
//     - Pulse goes straight to pulse_q. Caller guarantees pulse is synchronous to clk.
// TESTING  (TARGET=5, TIMEOUT=8, AUTO_RELOAD=0, clk period 10ns unless noted)
// 1 pulse=1 through reset, release rst, en=1, pulse held 1 -> count stays 0, no done.
// 2 en=1, five pulses (1 clk high, 1 clk low) -> count 1,2,3,4,5; done=1 after 5th edge.
//   Further pulses leave count=5.
// 3 two pulses, then pulse=0 for 8 clk -> timeout=1 on 8th idle clk, count=2, busy=0.
//   clear -> count=0, timeout=0.
// 4 rise arrives exactly on the clk where timer==7 -> count increments, timeout stays 0.
// 5 en dropped for 20 clk mid-run -> count/timer frozen, no timeout. Resume finishes normally.
// 6 AUTO_RELOAD=1, ten pulses -> done pulses 1 clk twice, count returns to 0 after each.
//   Also build with PULSE_SYNC_EN and repeat test 2: every increment is 2 clk later.

Source files
------------

// File: rtl/pulse_counter_watchdog.sv
// pulse_counter_watchdog
//   Counts rising edges of a level pulse input up to TARGET and raises done.
//   An inter-pulse watchdog raises timeout (sticky until clear) when TIMEOUT
//   consecutive enabled cycles pass without a counted edge.
//   Optional build macro: PULSE_SYNC_EN adds a 2-flop synchroniser (reset
//   value 1) in front of the edge detector for asynchronous pulse sources;
//   this adds 2 clk of edge-to-count latency.
//   Reset input rst is asynchronous and active-low; clear is the synchronous
//   return to IDLE.
module pulse_counter_watchdog #(
  parameter int CNT_W       = 4,
  parameter int TARGET      = 10,
  parameter int TO_W        = 8,
  parameter int TIMEOUT     = 100,
  parameter int AUTO_RELOAD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic             pulse,
  output logic [CNT_W-1:0] count,
  output logic             done,
  output logic             timeout,
  output logic             busy
);

  // Reject parameter values that the counter or timer cannot represent.
  generate
    if ((TARGET < 1) || (TARGET > ((2 ** CNT_W) - 1))) begin : g_bad_target
      $error("pulse_counter_watchdog: TARGET out of range 1..2^CNT_W-1");
    end
    if ((TIMEOUT < 1) || (TIMEOUT > ((2 ** TO_W) - 1))) begin : g_bad_timeout
      $error("pulse_counter_watchdog: TIMEOUT out of range 1..2^TO_W-1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2,
    ST_TOUT  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TARGET_C = CNT_W'(TARGET);
  localparam logic [TO_W-1:0]  TMAX_C   = TO_W'(TIMEOUT - 1);

  state_t           state_r, state_s;
  logic [CNT_W-1:0] count_r, count_s, cnt_inc_s;
  logic [TO_W-1:0]  timer_r, timer_s;
  logic             done_r, done_s;
  logic             timeout_r, timeout_s;
  logic             busy_r, busy_s;
  logic             pulse_in_s;
  logic             pulse_q_r;
  logic             rise_s;

`ifdef PULSE_SYNC_EN
  logic sync1_r, sync2_r;

  // Two-flop synchroniser; resets high so a level held through reset is not an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= pulse;
      sync2_r <= sync1_r;
    end
  end

  assign pulse_in_s = sync2_r;
`else
  assign pulse_in_s = pulse;
`endif

  // Previous pulse level for edge detection; resets high to mask a held pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pulse_q_r <= 1'b1;
    end else begin
      pulse_q_r <= pulse_in_s;
    end
  end

  assign rise_s    = pulse_in_s & ~pulse_q_r;
  assign cnt_inc_s = count_r + CNT_W'(1);

  // Next-state and next-output logic; clear overrides every state.
  always_comb begin
    state_s   = state_r;
    count_s   = count_r;
    timer_s   = timer_r;
    done_s    = done_r;
    timeout_s = timeout_r;
    if (clear) begin
      state_s   = ST_IDLE;
      count_s   = '0;
      timer_s   = '0;
      done_s    = 1'b0;
      timeout_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          count_s   = '0;
          timer_s   = '0;
          done_s    = 1'b0;
          timeout_s = 1'b0;
          if (en) begin
            state_s = ST_COUNT;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_COUNT: begin
          if (!en) begin
            state_s = ST_COUNT;
          end else if (rise_s) begin
            // An edge always beats a simultaneous watchdog expiry.
            count_s = cnt_inc_s;
            timer_s = '0;
            if (cnt_inc_s == TARGET_C) begin
              state_s = ST_DONE;
              done_s  = 1'b1;
            end else begin
              state_s = ST_COUNT;
            end
          end else if (timer_r == TMAX_C) begin
            state_s   = ST_TOUT;
            timeout_s = 1'b1;
          end else begin
            timer_s = timer_r + TO_W'(1);
          end
        end
        ST_DONE: begin
          if (AUTO_RELOAD != 0) begin
            // Reload cycle: any edge seen here is deliberately dropped.
            state_s = ST_COUNT;
            count_s = '0;
            timer_s = '0;
            done_s  = 1'b0;
          end else begin
            state_s = ST_DONE;
          end
        end
        ST_TOUT: begin
          state_s = ST_TOUT;
        end
        default: begin
          state_s   = ST_IDLE;
          count_s   = '0;
          timer_s   = '0;
          done_s    = 1'b0;
          timeout_s = 1'b0;
        end
      endcase
    end
    busy_s = (state_s == ST_COUNT);
  end

  // State, counter, timer and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      count_r   <= '0;
      timer_r   <= '0;
      done_r    <= 1'b0;
      timeout_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      count_r   <= count_s;
      timer_r   <= timer_s;
      done_r    <= done_s;
      timeout_r <= timeout_s;
      busy_r    <= busy_s;
    end
  end

  assign count   = count_r;
  assign done    = done_r;
  assign timeout = timeout_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_pulse_counter_watchdog.sv
// tb_pulse_counter_watchdog
//   Two instances share one stimulus stream: dut0 one-shot, dut1 auto-reload,
//   both TARGET=5, TIMEOUT=8. A reference model tracks expected outputs and is
//   compared every cycle; directed scenarios add literal expectations.
//   Honours PULSE_SYNC_EN (2 extra clk of edge latency in the model).
module tb_pulse_counter_watchdog;

  localparam int TGT = 5;
  localparam int TO  = 8;
`ifdef PULSE_SYNC_EN
  localparam int DLY = 2;
`else
  localparam int DLY = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic clear = 1'b0;
  logic pulse = 1'b1;
  logic [3:0] count0, count1;
  logic done0, done1, tout0, tout1, busy0, busy1;

  int n_checks = 0;
  int n_pass = 0;
  bit started = 1'b0;

  pulse_counter_watchdog #(.CNT_W(4), .TARGET(TGT), .TO_W(8), .TIMEOUT(TO), .AUTO_RELOAD(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .pulse(pulse),
    .count(count0), .done(done0), .timeout(tout0), .busy(busy0));

  pulse_counter_watchdog #(.CNT_W(4), .TARGET(TGT), .TO_W(8), .TIMEOUT(TO), .AUTO_RELOAD(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .pulse(pulse),
    .count(count1), .done(done1), .timeout(tout1), .busy(busy1));

  always #5 clk = ~clk;

  // phase: 0 waiting for enable, 1 running, 2 target reached, 3 stalled
  typedef struct {
    int phase;
    int cnt;
    int tmr;
    bit done;
    bit tout;
  } mdl_t;

  mdl_t m [2];
  bit   hist [$];

  function automatic mdl_t fresh();
    mdl_t z;
    z.phase = 0; z.cnt = 0; z.tmr = 0; z.done = 1'b0; z.tout = 1'b0;
    return z;
  endfunction

  // One clock of the rules: returns the state after this edge.
  function automatic mdl_t step(mdl_t c, bit rise, bit e, bit clr, bit reload);
    mdl_t n = c;
    if (clr) return fresh();
    if (c.phase == 0) begin
      if (e) n.phase = 1;
    end else if (c.phase == 1) begin
      if (e && rise) begin
        n.cnt = c.cnt + 1;
        n.tmr = 0;
        if (n.cnt == TGT) begin n.phase = 2; n.done = 1'b1; end
      end else if (e) begin
        if (c.tmr + 1 >= TO) begin n.phase = 3; n.tout = 1'b1; end
        else n.tmr = c.tmr + 1;
      end
    end else if (c.phase == 2) begin
      if (reload) begin n.phase = 1; n.cnt = 0; n.tmr = 0; n.done = 1'b0; end
    end
    return n;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Reference model: async reset, then one rule step per rising clock.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist.delete();
      for (int i = 0; i <= DLY; i++) hist.push_back(1'b1);
      m[0] = fresh();
      m[1] = fresh();
    end else begin
      bit r;
      hist.push_back(pulse);
      r = hist[1] & ~hist[0];
      void'(hist.pop_front());
      m[0] = step(m[0], r, en, clear, 1'b0);
      m[1] = step(m[1], r, en, clear, 1'b1);
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("count0", count0, m[0].cnt);
      chk("done0", done0, m[0].done);
      chk("timeout0", tout0, m[0].tout);
      chk("busy0", busy0, (m[0].phase == 1) ? 1 : 0);
      chk("count1", count1, m[1].cnt);
      chk("done1", done1, m[1].done);
      chk("timeout1", tout1, m[1].tout);
      chk("busy1", busy1, (m[1].phase == 1) ? 1 : 0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic pulses(input int n);
    repeat (n) begin
      pulse = 1'b1; cyc(1);
      pulse = 1'b0; cyc(1);
    end
  endtask

  // Clear to IDLE, flush the pulse pipeline, then enter COUNT with timer 0.
  task automatic restart();
    en = 1'b1; clear = 1'b1; pulse = 1'b0;
    cyc(1 + DLY);
    clear = 1'b0;
    cyc(1);
  endtask

  initial begin
    int dp;
    int mode;
    #1 rst = 1'b0;
    #2 started = 1'b1;
    cyc(3);
    chk("reset_count", count0, 0);
    chk("reset_busy", busy0, 0);

    // pulse held high through reset must not count
    rst = 1'b1; en = 1'b1;
    cyc(5 + DLY);
    chk("held_count", count0, 0);
    chk("held_done", done0, 0);

    // five edges reach the target, further edges ignored
    restart();
    pulses(5); cyc(DLY);
    chk("t2_count", count0, 5);
    chk("t2_done", done0, 1);
    pulses(3); cyc(DLY);
    chk("t2_hold", count0, 5);

    // stall after two edges
    restart();
    pulses(2);
    cyc(10 + DLY);
    chk("t3_count", count0, 2);
    chk("t3_timeout", tout0, 1);
    chk("t3_busy", busy0, 0);
    clear = 1'b1; cyc(1);
    chk("t3_clr_count", count0, 0);
    chk("t3_clr_timeout", tout0, 0);
    clear = 1'b0;

    // edge landing around the watchdog expiry cycle
    for (int j = 6 - DLY; j <= 8 - DLY; j++) begin
      restart();
      cyc(j);
      pulse = 1'b1; cyc(1);
      pulse = 1'b0; cyc(DLY);
      chk("t4_count", count0, (j + DLY <= 7) ? 1 : 0);
      chk("t4_timeout", tout0, (j + DLY <= 7) ? 0 : 1);
    end

    // pause mid-run
    restart();
    pulses(2); cyc(DLY);
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      pulse = 1'($urandom_range(0, 1));
      cyc(1);
    end
    pulse = 1'b0; cyc(2 + DLY);
    chk("t5_pause_count", count0, 2);
    chk("t5_pause_timeout", tout0, 0);
    en = 1'b1;
    pulses(3); cyc(DLY);
    chk("t5_count", count0, 5);
    chk("t5_done", done0, 1);
    chk("t5_timeout", tout0, 0);

    // auto-reload: ten edges give two one-cycle done pulses
    restart();
    dp = 0;
    for (int i = 0; i < 10; i++) begin
      pulse = 1'b1; cyc(1); dp += int'(done1);
      pulse = 1'b0; cyc(1); dp += int'(done1);
    end
    for (int i = 0; i < 3; i++) begin cyc(1); dp += int'(done1); end
    chk("t6_done_pulses", dp, 2);
    chk("t6_count", count1, 0);

    // asynchronous reset mid-run
    restart();
    pulses(2); cyc(DLY);
    rst = 1'b0; #1;
    chk("arst_count", count0, 0);
    chk("arst_busy", busy0, 0);
    cyc(1);
    rst = 1'b1;

    // randomized bursts
    for (int b = 0; b < 60; b++) begin
      mode = $urandom_range(0, 2);
      for (int c = 0; c < 30; c++) begin
        rst   = ($urandom_range(0, 199) != 0);
        clear = ($urandom_range(0, 39) == 0);
        en    = ($urandom_range(0, 9) != 0);
        case (mode)
          0: pulse = ~pulse;
          1: pulse = ($urandom_range(0, 7) == 0);
          default: pulse = 1'b0;
        endcase
        cyc(1);
      end
    end
    rst = 1'b1; clear = 1'b0;
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
